// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between instruction-fetch and data ports.
//            Round-robin arbitration is enabled by MEM_ARB_ROUND_ROBIN_EN;
//            otherwise the data port has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int MASK_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [MASK_W-1:0] d_byte_enable,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_byte_enable,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] be_q;

    logic w_d_req;
    logic w_any_req;
    logic w_grant_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 = data port was served last, so instruction port wins the next tie.
    logic rr_last_q;
`endif

    always_comb begin
        w_d_req   = d_read | d_write;
        w_any_req = w_d_req | i_read;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        w_grant_d = w_d_req & (~i_read | ~rr_last_q);
`else
        w_grant_d = w_d_req;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_last_q   <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_any_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        rr_last_q <= w_grant_d;
`endif
                        if (w_grant_d) begin
                            // A simultaneous read+write is served as a write.
                            state_q     <= BUSY_D;
                            addr_q      <= d_address;
                            wdata_q     <= d_wdata;
                            be_q        <= d_byte_enable;
                            mem_write_q <= d_write;
                            mem_read_q  <= ~d_write;
                        end else begin
                            state_q     <= BUSY_I;
                            addr_q      <= i_address;
                            be_q        <= '1;
                            mem_write_q <= 1'b0;
                            mem_read_q  <= 1'b1;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_resp) begin
                        state_q     <= DONE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_address     = addr_q;
    assign mem_wdata       = wdata_q;
    assign mem_byte_enable = be_q;
    assign busy            = (state_q != IDLE);

    // Responses are steered combinationally so the winner sees mem_resp in the same cycle.
    assign i_resp  = (state_q == BUSY_I) & mem_resp;
    assign d_resp  = (state_q == BUSY_D) & mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter with a transaction-level
//            arbitration model and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_read = 1'b0;
    logic [15:0] i_address = '0;
    logic [15:0] i_rdata;
    logic        i_resp;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [15:0] d_address = '0;
    logic [15:0] d_wdata = '0;
    logic [1:0]  d_byte_enable = '0;
    logic [15:0] d_rdata;
    logic        d_resp;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;
    logic        busy;

    int errors = 0;
    int checks = 0;
    // Model state: 1 when the data port was the last one granted.
    bit last_d = 1'b1;

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Called at a negedge while a transaction is in BUSY: respond, then let it return to IDLE.
    task automatic complete_txn();
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_read = 1'b1; i_address = 16'h0040;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_read, mem_write, busy, i_resp, d_resp} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 00000", {mem_read, mem_write, busy, i_resp, d_resp});
        end
        checks++;
        if ({mem_address, mem_wdata, mem_byte_enable} !== {16'h0000, 16'h0000, 2'b11}) begin
            errors++;
            $display("FAIL reset_latches: got %h/%h/%b expected 0000/0000/11", mem_address, mem_wdata, mem_byte_enable);
        end
        last_d = 1'b1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (mem_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_early: mem_read got %b expected 0", mem_read);
        end
        @(negedge clk);
        last_d = 1'b0;
        checks++;
        if ({mem_read, busy, mem_address} !== {1'b1, 1'b1, 16'h0040}) begin
            errors++;
            $display("FAIL reset_first_grant: got rd=%b busy=%b addr=%h expected 1 1 0040", mem_read, busy, mem_address);
        end
        complete_txn();
    endtask

    task automatic test_single_fetch();
        i_read = 1'b1; i_address = 16'h0040;
        @(negedge clk);
        last_d = 1'b0;
        checks++;
        if ({mem_read, mem_write, mem_address, mem_byte_enable} !== {1'b1, 1'b0, 16'h0040, 2'b11}) begin
            errors++;
            $display("FAIL fetch_grant: got rd=%b wr=%b addr=%h be=%b expected 1 0 0040 11", mem_read, mem_write, mem_address, mem_byte_enable);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({i_resp, d_resp, mem_read} !== 3'b001) begin
                errors++;
                $display("FAIL fetch_wait: got iresp=%b dresp=%b rd=%b expected 0 0 1", i_resp, d_resp, mem_read);
            end
        end
        mem_resp = 1'b1; mem_rdata = 16'h1234;
        #1;
        checks++;
        if ({i_resp, d_resp, i_rdata} !== {1'b1, 1'b0, 16'h1234}) begin
            errors++;
            $display("FAIL fetch_resp: got iresp=%b dresp=%b rdata=%h expected 1 0 1234", i_resp, d_resp, i_rdata);
        end
        i_read = 1'b0;
        @(negedge clk);
        mem_resp = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write, i_resp, busy} !== 4'b0001) begin
            errors++;
            $display("FAIL fetch_done: got rd=%b wr=%b iresp=%b busy=%b expected 0 0 0 1", mem_read, mem_write, i_resp, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fetch_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_data_write();
        d_write = 1'b1; d_address = 16'h3000; d_wdata = 16'hBEEF; d_byte_enable = 2'b01;
        @(negedge clk);
        last_d = 1'b1;
        checks++;
        if ({mem_write, mem_read, mem_address, mem_wdata, mem_byte_enable} !== {1'b1, 1'b0, 16'h3000, 16'hBEEF, 2'b01}) begin
            errors++;
            $display("FAIL write_grant: got wr=%b rd=%b addr=%h data=%h be=%b expected 1 0 3000 beef 01",
                     mem_write, mem_read, mem_address, mem_wdata, mem_byte_enable);
        end
        d_address = 16'h7777; d_wdata = 16'h0000; d_byte_enable = 2'b10;
        @(negedge clk);
        checks++;
        if ({mem_address, mem_wdata, mem_byte_enable} !== {16'h3000, 16'hBEEF, 2'b01}) begin
            errors++;
            $display("FAIL write_hold: got addr=%h data=%h be=%b expected 3000 beef 01", mem_address, mem_wdata, mem_byte_enable);
        end
        mem_resp = 1'b1;
        #1;
        checks++;
        if ({d_resp, i_resp} !== 2'b10) begin
            errors++;
            $display("FAIL write_resp: got dresp=%b iresp=%b expected 1 0", d_resp, i_resp);
        end
        complete_txn();
    endtask

    task automatic test_illegal();
        d_read = 1'b1; d_write = 1'b1; d_address = 16'h0ABC; d_wdata = 16'h5A5A; d_byte_enable = 2'b11;
        @(negedge clk);
        last_d = 1'b1;
        checks++;
        if ({mem_write, mem_read, mem_address} !== {1'b1, 1'b0, 16'h0ABC}) begin
            errors++;
            $display("FAIL illegal_rw: got wr=%b rd=%b addr=%h expected 1 0 0abc", mem_write, mem_read, mem_address);
        end
        complete_txn();
    endtask

    task automatic test_contention();
        bit exp_d;
        int n;
        i_read = 1'b1; d_read = 1'b1; i_address = 16'h0100; d_address = 16'h0200;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(mem_read | mem_write) && n < 6);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_d = ~last_d;
`else
            exp_d = 1'b1;
`endif
            last_d = exp_d;
            checks++;
            if (n !== ((k == 0) ? 1 : 2)) begin
                errors++;
                $display("FAIL contention_gap[%0d]: grant after %0d cycles expected %0d", k, n, (k == 0) ? 1 : 2);
            end
            checks++;
            if (mem_address !== (exp_d ? 16'h0200 : 16'h0100)) begin
                errors++;
                $display("FAIL contention_winner[%0d]: addr got %h expected %h", k, mem_address, exp_d ? 16'h0200 : 16'h0100);
            end
            mem_resp = 1'b1; mem_rdata = 16'($urandom);
            #1;
            checks++;
            if ({i_resp, d_resp} !== {~exp_d, exp_d}) begin
                errors++;
                $display("FAIL contention_resp[%0d]: got iresp=%b dresp=%b expected %b %b", k, i_resp, d_resp, ~exp_d, exp_d);
            end
            @(negedge clk);
            mem_resp = 1'b0;
        end
        i_read = 1'b0; d_read = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        d_write = 1'b1; d_address = 16'h5000; d_wdata = 16'hCAFE; d_byte_enable = 2'b10;
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_grant: mem_write got %b expected 1", mem_write);
        end
        #2;
        rst_n = 1'b0; mem_resp = 1'b1;
        #1;
        checks++;
        if ({mem_read, mem_write, busy, d_resp, i_resp} !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_abort: got %b expected 00000", {mem_read, mem_write, busy, d_resp, i_resp});
        end
        @(negedge clk);
        rst_n = 1'b1; mem_resp = 1'b0; last_d = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_write, mem_address, mem_wdata} !== {1'b1, 16'h5000, 16'hCAFE}) begin
            errors++;
            $display("FAIL rstmid_retry: got wr=%b addr=%h data=%h expected 1 5000 cafe", mem_write, mem_address, mem_wdata);
        end
        mem_resp = 1'b1;
        #1;
        checks++;
        if (d_resp !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_resp: d_resp got %b expected 1", d_resp);
        end
        complete_txn();
    endtask

    task automatic test_random();
        bit ir, dr, dw, dreq, win_d, exp_wr;
        logic [15:0] ia, da, dd, rd, exp_addr, exp_data;
        logic [1:0]  db, exp_be;
        int lat;
        for (int it = 0; it < 40; it++) begin
            ir = 1'($urandom); dr = 1'($urandom); dw = 1'($urandom);
            ia = 16'($urandom); da = 16'($urandom); dd = 16'($urandom); db = 2'($urandom);
            i_read = ir; d_read = dr; d_write = dw;
            i_address = ia; d_address = da; d_wdata = dd; d_byte_enable = db;
            dreq = dr | dw;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            win_d = dreq && !(ir && last_d);
`else
            win_d = dreq;
`endif
            @(negedge clk);
            if (!(ir | dreq)) begin
                checks++;
                if ({busy, mem_read, mem_write} !== 3'b000) begin
                    errors++;
                    $display("FAIL rand_idle[%0d]: got busy=%b rd=%b wr=%b expected 000", it, busy, mem_read, mem_write);
                end
                continue;
            end
            last_d   = win_d;
            exp_wr   = win_d & dw;
            exp_addr = win_d ? da : ia;
            exp_be   = win_d ? db : 2'b11;
            exp_data = dd;
            checks++;
            if ({busy, mem_read, mem_write, mem_address, mem_byte_enable} !== {1'b1, ~exp_wr, exp_wr, exp_addr, exp_be}) begin
                errors++;
                $display("FAIL rand_grant[%0d]: got rd=%b wr=%b addr=%h be=%b expected %b %b %h %b",
                         it, mem_read, mem_write, mem_address, mem_byte_enable, ~exp_wr, exp_wr, exp_addr, exp_be);
            end
            if (exp_wr) begin
                checks++;
                if (mem_wdata !== exp_data) begin
                    errors++;
                    $display("FAIL rand_wdata[%0d]: got %h expected %h", it, mem_wdata, exp_data);
                end
            end
            // Requesters wander (and may even drop the request); the latched request must persist.
            i_address = 16'($urandom); d_address = 16'($urandom); d_wdata = 16'($urandom);
            d_byte_enable = 2'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
            end
            lat = $urandom_range(0, 3);
            repeat (lat) @(negedge clk);
            checks++;
            if ({mem_read, mem_write, mem_address, mem_byte_enable} !== {~exp_wr, exp_wr, exp_addr, exp_be}) begin
                errors++;
                $display("FAIL rand_hold[%0d]: got rd=%b wr=%b addr=%h be=%b expected %b %b %h %b",
                         it, mem_read, mem_write, mem_address, mem_byte_enable, ~exp_wr, exp_wr, exp_addr, exp_be);
            end
            rd = 16'($urandom);
            mem_rdata = rd; mem_resp = 1'b1;
            #1;
            checks++;
            if ({i_resp, d_resp, i_rdata, d_rdata} !== {~win_d, win_d, rd, rd}) begin
                errors++;
                $display("FAIL rand_resp[%0d]: got iresp=%b dresp=%b irdata=%h drdata=%h expected %b %b %h",
                         it, i_resp, d_resp, i_rdata, d_rdata, ~win_d, win_d, rd);
            end
            i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
            @(negedge clk);
            mem_resp = 1'b0;
            #1;
            checks++;
            if ({busy, mem_read, mem_write, i_resp, d_resp} !== 5'b10000) begin
                errors++;
                $display("FAIL rand_done[%0d]: got %b expected 10000", it, {busy, mem_read, mem_write, i_resp, d_resp});
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_data_write();
        test_illegal();
        test_contention();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one physical memory port between the instruction-fetch requester and the data-access requester of the lc3b control/datapath.
- Each requester uses the same mem_read/mem_write/mem_resp handshake the control FSM already drives, so the control FSM is unchanged.
- The arbiter latches the winning request and holds it stable on the memory side until mem_resp.
- It then returns the response to the winner only, and inserts one recovery cycle before the next arbitration.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MASK_W, 2, byte-enable width (DATA_W/8).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  instruction port read request, held until i_resp
- i_address  in  ADDR_W  instruction port address
- i_rdata  out  DATA_W  instruction read data, valid when i_resp=1
- i_resp  out  1  instruction port response, one-cycle pulse
- d_read  in  1  data port read request, held until d_resp
- d_write  in  1  data port write request, held until d_resp
- d_address  in  ADDR_W  data port address
- d_wdata  in  DATA_W  data port write data
- d_byte_enable  in  MASK_W  data port write byte mask
- d_rdata  out  DATA_W  data read data, valid when d_resp=1
- d_resp  out  1  data port response, one-cycle pulse
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_byte_enable  out  MASK_W  memory byte mask
- mem_rdata  in  DATA_W  memory read data
- mem_resp  in  1  memory response
- busy  out  1  arbiter owns the memory (state not IDLE)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - mem_read=mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=2'b11.
  - i_resp=d_resp=0, busy=0, rr_last=DATA (favours I first under round-robin).
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE:
  - Sample requests. If none, stay in IDLE.
  - Winner per priority rule (fixed: data over instruction).
  - On the grant edge, register address, wdata and byte_enable into the output latches, and register the op (read/write).
  - Go to BUSY_I or BUSY_D.
- Latency: request seen at edge N; mem_read/mem_write asserted from cycle N+1. Minimum 1 cycle of arbitration latency.
- BUSY_x:
  - mem_read/mem_write held from the latched op. Address, data and mask are stable, unaffected by requester input changes.
  - When mem_resp=1, the same cycle asserts x_resp=1 and x_rdata=mem_rdata, combinationally from mem_resp. The other port's resp stays 0.
  - Next edge: DONE, and strobes drop.
- DONE:
  - One cycle with all strobes 0 and no grant. This lets the served requester drop its request, preventing a double service.
  - Next state is IDLE unconditionally.
- Read data:
  - i_rdata and d_rdata both mirror mem_rdata at all times.
  - Consumers qualify with resp only.
- d_read and d_write both asserted (illegal): treated as a write. Write strobe only, read ignored.
- Requester dropping its request while BUSY (protocol violation): the transaction still completes, and resp is still pulsed.
- Instruction port is read-only. For it, mem_write=0 and mem_byte_enable=2'b11.
- Back-to-back throughput: one transaction per (memory latency + 2) cycles.
- Async reset mid-transaction: strobes drop immediately, with no resp. Memory-side abandonment is acceptable.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - When both ports request in IDLE, the grant goes to the port not served last (rr_last).
  - rr_last updates on every grant.
- Undefined:
  - Fixed priority, data port always wins.
  - rr_last is not implemented.

Test Plan:
- Reset: hold rst_n=0 with i_read=1 -> all mem strobes 0, busy=0. After release, mem_read rises one cycle after first IDLE sample.
- Single I fetch:
  - Stimulus: i_address=16'h0040, mem_resp after 3 cycles with mem_rdata=16'h1234.
  - Required: mem_address=16'h0040, i_resp 1-cycle pulse with i_rdata=16'h1234, d_resp=0, then DONE, then IDLE.
- Data write:
  - Stimulus: d_write=1, d_address=16'h3000, d_wdata=16'hBEEF, d_byte_enable=2'b01.
  - Required: mem_write=1 with those values latched.
  - Then change d_address mid-BUSY -> mem_address stays 16'h3000, d_resp pulses on mem_resp.
- Contention:
  - Stimulus: i_read and d_read asserted the same cycle and held, repeated 4 transactions.
  - Required, fixed mode: D,D,D,D.
  - Required, MEM_ARB_ROUND_ROBIN_EN: I,D,I,D.
- Illegal d_read+d_write=1 -> mem_write=1, mem_read=0.
- Reset mid-BUSY_D: rst_n pulsed low -> mem_write drops asynchronously, no d_resp. Next request is served normally.
